// File: rtl/keypad_if.sv
// Keypad pin and key-event bundle between the scan controller (master)
// and the keypad matrix / display consumer (slave).
interface keypad_if;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       key_held;
    logic [3:0] digit_new;
    logic [3:0] digit_old;

    modport master (
        input  row,
        input  key_ready,
        output col,
        output key_valid,
        output key_code,
        output key_held,
        output digit_new,
        output digit_old
    );

    modport slave (
        output row,
        output key_ready,
        input  col,
        input  key_valid,
        input  key_code,
        input  key_held,
        input  digit_new,
        input  digit_old
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column strobe with settle time, press/release debounce,
// one valid/ready key event per press, and a two-digit history for the display.
module keypad_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES   = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.master kp
);

    localparam int unsigned SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned DCNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE_CYCLES - 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DB_PRESS = 2'd1,
        HELD     = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         row_meta_q, row_s_q;
    logic [1:0]         col_idx_q, col_idx_d;
    logic [1:0]         row_idx_q, row_idx_d;
    logic [SCNT_W-1:0]  scnt_q, scnt_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic [3:0]         col_q, col_d;
    logic               key_valid_q, key_valid_d;
    logic [3:0]         key_code_q, key_code_d;
    logic               key_held_q, key_held_d;
    logic [3:0]         digit_new_q, digit_new_d;
    logic [3:0]         digit_old_q, digit_old_d;

    function automatic logic [1:0] row_enc(input logic [3:0] r);
        if (r[3])      return 2'd3;
        else if (r[2]) return 2'd2;
        else if (r[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    function automatic logic [3:0] key_decode(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] code;
        case ({c, r})
            4'h0: code = 4'hA;  4'h1: code = 4'h7;  4'h2: code = 4'h4;  4'h3: code = 4'h1;
            4'h4: code = 4'h0;  4'h5: code = 4'h8;  4'h6: code = 4'h5;  4'h7: code = 4'h2;
            4'h8: code = 4'hB;  4'h9: code = 4'h9;  4'hA: code = 4'h6;  4'hB: code = 4'h3;
            4'hC: code = 4'hF;  4'hD: code = 4'hE;  4'hE: code = 4'hD;  default: code = 4'hC;
        endcase
        return code;
    endfunction

    logic       scan_eval_c, row_single_c, press_match_c, release_bit_c;
    logic [3:0] decode_c;

    assign scan_eval_c   = (state_q == SCAN) && (scnt_q == SCNT_LAST);
    assign row_single_c  = $onehot(row_s_q);
    assign press_match_c = (row_s_q == (4'b0001 << row_idx_q));
    assign release_bit_c = row_s_q[row_idx_q];
    assign decode_c      = key_decode(col_idx_q, row_idx_q);

    // Row synchronizer and state register
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q <= 4'b0;
            row_s_q    <= 4'b0;
            state_q    <= SCAN;
        end else begin
            row_meta_q <= kp.row;
            row_s_q    <= row_meta_q;
            state_q    <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN:     if (scan_eval_c && row_single_c) state_d = DB_PRESS;
            DB_PRESS: begin
                if (!press_match_c)
                    state_d = SCAN;
                else if (dcnt_q == DCNT_LAST && !key_valid_q)
                    state_d = HELD;
            end
            HELD:     if (!release_bit_c && dcnt_q == DCNT_LAST) state_d = SCAN;
            default:  state_d = SCAN;
        endcase
    end

    // Counters, event handshake and digit history
    always_comb begin
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        scnt_d      = scnt_q;
        dcnt_d      = dcnt_q;
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        digit_new_d = digit_new_q;
        digit_old_d = digit_old_q;

        if (key_valid_q && kp.key_ready)
            key_valid_d = 1'b0;

        case (state_q)
            SCAN: begin
                if (scan_eval_c) begin
                    scnt_d = '0;
                    if (row_single_c) begin
                        row_idx_d = row_enc(row_s_q);
                        dcnt_d    = '0;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    scnt_d = scnt_q + SCNT_W'(1);
                end
            end
            DB_PRESS: begin
                if (!press_match_c) begin
                    scnt_d = '0;
                    dcnt_d = '0;
                end else if (dcnt_q != DCNT_LAST) begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end else if (!key_valid_q) begin
                    // A pending event is never overwritten; dcnt saturates until it drains.
                    key_valid_d = 1'b1;
                    key_code_d  = decode_c;
                    digit_old_d = digit_new_q;
                    digit_new_d = decode_c;
                    dcnt_d      = '0;
                end
            end
            HELD: begin
                if (release_bit_c) begin
                    dcnt_d = '0;
                end else if (dcnt_q == DCNT_LAST) begin
                    dcnt_d = '0;
                    scnt_d = '0;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            default: ;
        endcase

        col_d      = 4'b0001 << col_idx_d;
        key_held_d = (state_d == HELD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            scnt_q      <= '0;
            dcnt_q      <= '0;
            col_q       <= 4'b0001;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_held_q  <= 1'b0;
            digit_new_q <= 4'h0;
            digit_old_q <= 4'h0;
        end else begin
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            scnt_q      <= scnt_d;
            dcnt_q      <= dcnt_d;
            col_q       <= col_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            digit_new_q <= digit_new_d;
            digit_old_q <= digit_old_d;
        end
    end

    assign kp.col       = col_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_held  = key_held_q;
    assign kp.digit_new = digit_new_q;
    assign kp.digit_old = digit_old_q;

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequencer for the 4x4 matrix keypad.
- Drives one-hot column strobes and waits a settle time before sampling the rows.
- Debounces both press and release, decodes a single-key press into a hex code, and delivers exactly one key event per press over a valid/ready handshake.
- Keeps the two most recent digits for the dual seven-segment display path.
- Sits between the keypad pins and the display multiplexer, and replaces free-running per-cycle scanning.

Parameters:
- SETTLE_CYCLES, 4, clock cycles a column is driven before the rows are evaluated (minimum 1).
- DEBOUNCE_CYCLES, 8, consecutive stable cycles required to accept a press or a release (minimum 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- row  in  4  raw keypad row inputs; a row is asserted high; asynchronous to clk.
- col  out  4  one-hot column drive, registered.
- key_valid  out  1  key event pending.
- key_code  out  4  hex code of the pending event; stable while key_valid=1.
- key_ready  in  1  consumer accepts the event.
- key_held  out  1  high while a debounced key is held.
- digit_new  out  4  most recent accepted key code.
- digit_old  out  4  previous value of digit_new.

Behaviour:
- Row synchronizer: row passes through a 2-flop synchronizer to produce row_s. All decisions use row_s only.
- Reset values (applied one edge after rst=1; a mid-operation reset drops any pending event):
  - state=SCAN, col_idx=0, col=4'b0001
  - all counters 0
  - key_valid=0, key_code=0, key_held=0, digit_new=0, digit_old=0
- Column drive: col = 1<<col_idx in every state. The column changes only when leaving SCAN with no key found.
- Key map (col_idx,row bit -> code):
  - col0: row0=A, row1=7, row2=4, row3=1
  - col1: row0=0, row1=8, row2=5, row3=2
  - col2: row0=B, row1=9, row2=6, row3=3
  - col3: row0=F, row1=E, row2=D, row3=C
- SCAN state:
  - scnt counts 0..SETTLE_CYCLES-1.
  - At scnt==SETTLE_CYCLES-1, row_s is evaluated:
    - Exactly one bit set: latch row_idx, go DB_PRESS with dcnt=0.
    - Zero bits or two or more bits set (ghosting): col_idx <= col_idx+1 (wraps 3->0), scnt=0, stay in SCAN.
- DB_PRESS state:
  - Each cycle, if row_s == 1<<row_idx then dcnt increments; otherwise go SCAN on the same column with scnt=0.
  - When dcnt==DEBOUNCE_CYCLES-1 and the match holds:
    - If key_valid=0: set key_valid=1, key_code=decode, digit_old<=digit_new, digit_new<=decode; go HELD.
    - If key_valid=1 (previous event not yet taken): dcnt saturates and the state holds until key_valid=0. No event is ever overwritten.
- HELD state:
  - key_held=1.
  - Only bit row_idx is watched; presses on other rows or columns are ignored.
  - dcnt counts consecutive cycles with row_s[row_idx]=0; any 1 clears dcnt.
  - At DEBOUNCE_CYCLES zeros: go SCAN on the same column with scnt=0.
- Handshake:
  - The event transfers on an edge where key_valid & key_ready; key_valid clears on that edge.
  - key_ready is a don't-care while key_valid=0.
  - key_valid never drops without a transfer (except on rst).
  - key_ready held high: key_valid is high for exactly 1 cycle.
- Latency: key_valid rises DEBOUNCE_CYCLES cycles after DB_PRESS entry, given a stable press and an idle consumer.
- Implemented states: SCAN, DB_PRESS, HELD.

Test Plan:
1. Reset with row=0, 40 idle cycles -> col walks 0001,0010,0100,1000,0001, changing every 4 cycles; key_valid stays 0.
2. Hold row=0100 while col=0010, key_ready=1 -> key_code=5, key_valid high exactly 1 cycle, digit_new=5, digit_old=0, key_held=1, col frozen at 0010.
3. Second press: release debounced, then press col3/row0 -> key_code=F, digit_new=F, digit_old=5; scanning resumes after 8 cycles of row low.
4. Bounce: row toggles every 3 cycles for 30 cycles, then stable for 8 -> exactly one event; no event during bounce.
5. Ghost/back-pressure:
   - row=0011 -> no event, column advances.
   - key_ready=0 while event 7 pending, then release and press 9 -> key_valid stays with code 7 until key_ready; 9 is emitted after the transfer.
6. Reset mid-HELD with key_valid=1 -> next cycle key_valid=0, col=0001, digits=0.
